// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline stages.
// The MEM stage FSM states and the data-memory geometry defaults live here.
package pipeline_pkg;

  localparam int MEM_ADDR_BASE = 1024;
  localparam int WORD_W        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem_array.sv
// Word-wide data memory: synchronous write, asynchronous read.
// Contents are never reset, so they survive a pipeline reset.
module data_mem_array
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[widx_i] <= wdata_i;
  end

  assign rdata_o = mem[ridx_i];

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage in front of a slow SRAM. Each access spends WAIT_CYCLES in BUSY,
// holding ready low so the whole pipeline freezes until the DONE cycle.
module mem_stage_sram
  import pipeline_pkg::*;
#(
  parameter int ADDR_BASE   = MEM_ADDR_BASE,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [WORD_W-1:0] ALU_result,
  input  logic [WORD_W-1:0] ST_value,
  output logic [WORD_W-1:0] rd_data,
  output logic              ready,
  output logic              addr_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  mem_state_e        state_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, data_q, rd_data_q;
  logic              st_q, addr_err_q;

  logic              req;
  logic [WORD_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              illegal, last_busy, mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign req = MEM_R_EN | MEM_W_EN;

  // Decode works on the latched address so a changing bus cannot disturb the access.
  assign off     = addr_q - WORD_W'(ADDR_BASE);
  assign idx     = off[IDX_W+1:2];
  assign illegal = (addr_q < WORD_W'(ADDR_BASE)) || ((off >> 2) >= WORD_W'(DEPTH)) ||
                   (addr_q[1:0] != 2'b00);

  assign cnt_d     = cnt_q - 4'd1;
  assign last_busy = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we    = last_busy && st_q && !illegal;

  data_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .widx_i  (idx),
    .wdata_i (data_q),
    .ridx_i  (idx),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      st_q       <= 1'b0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_err_q <= 1'b0;
          if (req) begin
            addr_q  <= ALU_result;
            data_q  <= ST_value;
            st_q    <= MEM_W_EN;   // store wins when both enables are high
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (illegal) begin
              rd_data_q  <= '0;
              addr_err_q <= 1'b1;
            end else if (!st_q) begin
              rd_data_q  <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          // Requests are ignored here so a held enable cannot retrigger.
          state_q    <= IDLE;
          addr_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready    = !rst || ((state_q == IDLE) && !req) || (state_q == DONE);
  assign rd_data  = rd_data_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: directed vector table, reset/hold sequences,
// and randomized accesses against a word-array reference model.
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] addr = '0, st = '0;
  logic [31:0] rd_data;
  logic        ready, addr_err;

  int checks = 0;
  int errors = 0;

  mem_stage_sram dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (r_en),
    .MEM_W_EN   (w_en),
    .ALU_result (addr),
    .ST_value   (st),
    .rd_data    (rd_data),
    .ready      (ready),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r, w;
    logic [31:0] a, d;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          chk_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One access: drive after a rising edge, count ready=0 cycles, sample DONE.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output logic [31:0] rd, output bit err,
                        output int lat, output bit early_err);
    @(posedge clk); #1;
    r_en = r; w_en = w; addr = a; st = d;
    lat = 0; early_err = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (addr_err) early_err = 1;
    end
    rd = rd_data; err = addr_err;
    if (!hold) begin
      @(posedge clk); #1;
      r_en = 0; w_en = 0;
    end
  endtask

  task automatic run_check(input string nm, input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err,
                           input bit chk_rd, input bit hold);
    logic [31:0] rd; bit err; int lat; bit early;
    access(r, w, a, d, hold, rd, err, lat, early);
    chk($sformatf("%s latency", nm), lat, 32'd6);
    chk($sformatf("%s early_err", nm), {31'd0, early}, 32'd0);
    chk($sformatf("%s addr_err", nm), {31'd0, err}, {31'd0, exp_err});
    if (chk_rd) chk($sformatf("%s rd_data", nm), rd, exp_rd);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a >= 32'd1024) && (a % 4 == 0) && ((a - 32'd1024) / 4 < 64);
  endfunction

  vec_t        vt[11];
  logic [31:0] mem_m[64];
  logic [31:0] rd_last;

  initial begin
    // Reset with a pending request: outputs must still read idle and ready.
    r_en = 1; addr = 32'd1032;
    #12;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset addr_err", {31'd0, addr_err}, 32'd0);
    r_en = 0;
    @(posedge clk); #1 rst = 1;

    vt[0]  = '{r:0, w:1, a:1024, d:32'h11111111, exp_rd:0,            exp_err:0, chk_rd:1};
    vt[1]  = '{r:0, w:1, a:1032, d:32'hDEADBEEF, exp_rd:0,            exp_err:0, chk_rd:1};
    vt[2]  = '{r:1, w:0, a:1032, d:0,            exp_rd:32'hDEADBEEF, exp_err:0, chk_rd:1};
    vt[3]  = '{r:1, w:0, a:1000, d:0,            exp_rd:0,            exp_err:1, chk_rd:1};
    vt[4]  = '{r:0, w:1, a:1026, d:32'h55,       exp_rd:0,            exp_err:1, chk_rd:1};
    vt[5]  = '{r:1, w:0, a:1024, d:0,            exp_rd:32'h11111111, exp_err:0, chk_rd:1};
    vt[6]  = '{r:1, w:1, a:1028, d:32'd7,        exp_rd:32'h11111111, exp_err:0, chk_rd:1};
    vt[7]  = '{r:1, w:0, a:1028, d:0,            exp_rd:32'd7,        exp_err:0, chk_rd:1};
    vt[8]  = '{r:1, w:0, a:1280, d:0,            exp_rd:0,            exp_err:1, chk_rd:1};
    vt[9]  = '{r:0, w:1, a:1276, d:32'hA5A5,     exp_rd:0,            exp_err:0, chk_rd:1};
    vt[10] = '{r:1, w:0, a:1276, d:0,            exp_rd:32'hA5A5,     exp_err:0, chk_rd:1};
    for (int i = 0; i < 11; i++)
      run_check($sformatf("vec%0d", i), vt[i].r, vt[i].w, vt[i].a, vt[i].d,
                vt[i].exp_rd, vt[i].exp_err, vt[i].chk_rd, 0);

    // Reset during BUSY of a store: the write must be dropped.
    run_check("pre_store", 0, 1, 1036, 32'd5, 32'hA5A5, 0, 1, 0);
    @(posedge clk); #1;
    w_en = 1; addr = 32'd1036; st = 32'd9;
    repeat (3) @(negedge clk);
    chk("busy ready", {31'd0, ready}, 32'd0);
    rst = 0; #1;
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst rd_data", rd_data, 32'd0);
    chk("midrst addr_err", {31'd0, addr_err}, 32'd0);
    w_en = 0;
    @(posedge clk); #1 rst = 1;
    run_check("post_rst load", 1, 0, 1036, 0, 32'd5, 0, 1, 0);

    // Held load: one access, then one IDLE cycle with ready=0 before the next.
    run_check("hold1", 1, 0, 1024, 0, 32'h11111111, 0, 1, 1);
    run_check("hold2", 1, 0, 1024, 0, 32'h11111111, 0, 1, 0);

    // Randomized phase: fill the model, then mix legal/illegal loads and stores.
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = $urandom;
      run_check($sformatf("fill%0d", i), 0, 1, 32'd1024 + 32'(4 * i), mem_m[i], 0, 0, 0, 0);
    end
    run_check("rnd_init", 1, 0, 1020, 0, 32'd0, 1, 1, 0);
    rd_last = 0;
    for (int n = 0; n < 80; n++) begin
      int sel, op; logic [31:0] a, d; bit r, w, e;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'd1024 + 32'(4 * $urandom_range(0, 63));
      else if (sel == 7) a = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(0, 1023));
      else               a = 32'd1280 + 32'($urandom_range(0, 1000));
      op = $urandom_range(0, 2);
      r = (op != 1); w = (op != 0); d = $urandom;
      e = !legal(a);
      if (e)      rd_last = 0;
      else if (w) mem_m[(a - 1024) / 4] = d;
      else        rd_last = mem_m[(a - 1024) / 4];
      run_check($sformatf("rnd%0d a=%0d", n, a), r, w, a, d, rd_last, e, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
